// File: rtl/snake_head_ctrl.sv
// Snake-head motion controller: qualifies one-hot buttons, latches a pending direction and
// steps the head one cell every STEP_DIV enabled cycles. Define SNAKE_WRAP_EN for wrap-around edges.
module snake_head_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HEIGHT   = 8,
  parameter int unsigned XW       = 4,
  parameter int unsigned YW       = 4,
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned START_X  = 0,
  parameter int unsigned START_Y  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          restart,
  input  logic          btnUp,
  input  logic          btnDown,
  input  logic          btnLeft,
  input  logic          btnRight,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [1:0]    dir,
  output logic          step,
  output logic          hit
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_START  = XW'(START_X);
  localparam logic [YW-1:0] Y_START  = YW'(START_Y);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t        state, state_n;
  logic [1:0]    pend, pend_n, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] x_n, nx;
  logic [YW-1:0] y_n, ny;
  logic          step_n, hit_n;
  logic [3:0]    btns;
  logic          press_valid;
  logic [1:0]    press_dir;
  logic          terminal;
  logic          blocked;

  // Exactly one button high qualifies a press
  assign btns        = {btnUp, btnLeft, btnDown, btnRight};
  assign press_valid = $onehot(btns);
  assign terminal    = (state == S_RUN) && enable && (cnt == CNT_LAST);

  always_comb begin
    press_dir = DIR_RIGHT;
    case (btns)
      4'b0010: press_dir = DIR_DOWN;
      4'b0100: press_dir = DIR_LEFT;
      4'b1000: press_dir = DIR_UP;
      default: press_dir = DIR_RIGHT;
    endcase
  end

  // Candidate head position for the pending direction; edges are checked before any arithmetic
  always_comb begin
    nx      = x;
    ny      = y;
    blocked = 1'b0;
    unique case (pend)
      DIR_RIGHT:
        if (x == X_LAST) begin
`ifdef SNAKE_WRAP_EN
          nx = '0;
`else
          blocked = 1'b1;
`endif
        end else nx = x + XW'(1);
      DIR_LEFT:
        if (x == '0) begin
`ifdef SNAKE_WRAP_EN
          nx = X_LAST;
`else
          blocked = 1'b1;
`endif
        end else nx = x - XW'(1);
      DIR_DOWN:
        if (y == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
          ny = '0;
`else
          blocked = 1'b1;
`endif
        end else ny = y + YW'(1);
      DIR_UP:
        if (y == '0) begin
`ifdef SNAKE_WRAP_EN
          ny = Y_LAST;
`else
          blocked = 1'b1;
`endif
        end else ny = y - YW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (restart) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (press_valid) state_n = S_RUN;
        S_RUN:   if (terminal && blocked) state_n = S_DEAD;
        S_DEAD:  state_n = S_DEAD;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath next values; reversal is judged against the committed direction
  always_comb begin
    x_n    = x;
    y_n    = y;
    dir_n  = dir;
    pend_n = pend;
    cnt_n  = cnt;
    step_n = 1'b0;
    hit_n  = hit;
    if (restart) begin
      x_n    = X_START;
      y_n    = Y_START;
      dir_n  = DIR_RIGHT;
      pend_n = DIR_RIGHT;
      cnt_n  = '0;
      hit_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (press_valid) pend_n = press_dir;
        end
        S_RUN: begin
          if (press_valid && (press_dir != (dir ^ 2'b10))) pend_n = press_dir;
          if (enable) begin
            if (cnt == CNT_LAST) begin
              cnt_n = '0;
              if (blocked) hit_n = 1'b1;
              else begin
                x_n    = nx;
                y_n    = ny;
                dir_n  = pend;
                step_n = 1'b1;
              end
            end else cnt_n = cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
`ifdef SNAKE_WRAP_EN
    hit_n = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x    <= X_START;
      y    <= Y_START;
      dir  <= DIR_RIGHT;
      pend <= DIR_RIGHT;
      cnt  <= '0;
      step <= 1'b0;
      hit  <= 1'b0;
    end else begin
      x    <= x_n;
      y    <= y_n;
      dir  <= dir_n;
      pend <= pend_n;
      cnt  <= cnt_n;
      step <= step_n;
      hit  <= hit_n;
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Randomized bench for snake_head_ctrl against a grid-level reference model.
module tb_snake_head_ctrl;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int DIV = 4;
  localparam int XW  = 4;
  localparam int YW  = 4;

  logic          clk = 1'b0;
  logic          reset, enable, restart;
  logic          btnUp, btnDown, btnLeft, btnRight;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    dir;
  logic          step, hit;

  int compares = 0;
  int fails    = 0;

  // Reference model: position, direction, pending turn, phase counter, mode (0 idle, 1 run, 2 dead)
  int mx, my, mdir, mpend, mcnt, mst;
  bit mstep, mhit;

  snake_head_ctrl #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .STEP_DIV(DIV), .START_X(0), .START_Y(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .x(x), .y(y), .dir(dir), .step(step), .hit(hit)
  );

  always #5 clk = ~clk;

  function automatic logic [XW+YW+3:0] exp_vec();
    return {4'(mx), 4'(my), 2'(mdir), mstep, mhit};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mdir = 0; mpend = 0; mcnt = 0; mst = 0; mstep = 0; mhit = 0;
  endtask

  // b = {up, down, left, right}
  task automatic model_edge(input bit rs, input bit en, input bit [3:0] b);
    int pd, nx, ny, od, op;
    bit single;
    single = (b == 4'b1000) || (b == 4'b0100) || (b == 4'b0010) || (b == 4'b0001);
    pd = b[0] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    mstep = 0;
    if (rs) begin
      model_reset();
      return;
    end
    if (mst == 0) begin
      mcnt = 0;
      if (single) begin mpend = pd; mst = 1; end
    end else if (mst == 1) begin
      od = mdir;
      op = mpend;
      if (single && pd != (od + 2) % 4) mpend = pd;
      if (en) begin
        if (mcnt == DIV - 1) begin
          mcnt = 0;
          nx = mx + ((op == 0) ? 1 : (op == 2) ? -1 : 0);
          ny = my + ((op == 1) ? 1 : (op == 3) ? -1 : 0);
          if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
            mx = nx; my = ny; mdir = op; mstep = 1;
          end else begin
`ifdef SNAKE_WRAP_EN
            mx = (nx + W) % W; my = (ny + H) % H; mdir = op; mstep = 1;
`else
            mhit = 1; mst = 2;
`endif
          end
        end else mcnt++;
      end
    end
  endtask

  task automatic tick(input bit rs, input bit en, input bit [3:0] b);
    restart = rs;
    enable  = en;
    {btnUp, btnDown, btnLeft, btnRight} = b;
    @(posedge clk);
    model_edge(rs, en, b);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; restart = 0; enable = 0;
    {btnUp, btnDown, btnLeft, btnRight} = 4'b0;
    model_reset();
    #12;
    compares++;
    if ({x, y, dir, step, hit} !== 12'h000) begin
      fails++; $display("FAIL reset_async got=%h exp=%h", {x, y, dir, step, hit}, 12'h000);
    end
    @(posedge clk); #1;
    compares++;
    if ({x, y, dir, step, hit} !== exp_vec()) begin
      fails++; $display("FAIL reset_held got=%h exp=%h", {x, y, dir, step, hit}, exp_vec());
    end
    #3 reset = 1'b1;
  endtask

  task automatic test_idle();
    bit saw_step = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 4'b0000);
      saw_step |= step;
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL idle c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (x !== 4'd0 || y !== 4'd0 || saw_step) begin
      fails++; $display("FAIL idle_hold x=%0d y=%0d step_seen=%0d exp x=0 y=0 step_seen=0", x, y, saw_step);
    end
  endtask

  task automatic test_start();
    tick(0, 1, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL start c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (x !== 4'd1 || step !== 1'b1) begin
      fails++; $display("FAIL first_move x=%0d step=%0d exp x=1 step=1", x, step);
    end
    tick(0, 1, 4'b0000);
    compares++;
    if (step !== 1'b0) begin
      fails++; $display("FAIL step_width step=%0d exp=0", step);
    end
  endtask

  task automatic test_reversal();
    tick(0, 1, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL reverse c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (dir !== 2'd0 || x !== 4'd3) begin
      fails++; $display("FAIL reverse_ignored dir=%0d x=%0d exp dir=0 x=3", dir, x);
    end
    tick(0, 1, 4'b0100);
    tick(0, 1, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL quick_turn c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (dir !== 2'd1 || y === 4'd0) begin
      fails++; $display("FAIL quick_turn_dir dir=%0d y=%0d exp dir=1 y>0", dir, y);
    end
  endtask

  task automatic test_multi_enable();
    int fy, fx;
    tick(0, 1, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL multi c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (dir !== 2'd1) begin
      fails++; $display("FAIL multi_ignored dir=%0d exp=1", dir);
    end
    tick(0, 1, 4'b0000);
    fx = mx; fy = my;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 4'b0000);
      compares++;
      if (x !== 4'(fx) || y !== 4'(fy) || step !== 1'b0) begin
        fails++; $display("FAIL freeze c=%0d x=%0d y=%0d step=%0d exp x=%0d y=%0d step=0", i, x, y, step, fx, fy);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL resume c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
  endtask

  task automatic test_wall();
    tick(1, 0, 4'b0000);
    tick(0, 1, 4'b0001);
    for (int i = 0; i < 60; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL wall_run c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
    compares++;
    if (x !== 4'd15) begin
      fails++; $display("FAIL wall_reach x=%0d exp=15", x);
    end
    repeat (4) tick(0, 1, 4'b0000);
`ifdef SNAKE_WRAP_EN
    compares++;
    if (x !== 4'd0 || step !== 1'b1 || hit !== 1'b0) begin
      fails++; $display("FAIL wrap_x x=%0d step=%0d hit=%0d exp x=0 step=1 hit=0", x, step, hit);
    end
    tick(0, 1, 4'b1000);
    repeat (3) tick(0, 1, 4'b0000);
    compares++;
    if (y !== 4'd7 || dir !== 2'd3 || step !== 1'b1) begin
      fails++; $display("FAIL wrap_y y=%0d dir=%0d step=%0d exp y=7 dir=3 step=1", y, dir, step);
    end
`else
    compares++;
    if (x !== 4'd15 || hit !== 1'b1 || step !== 1'b0) begin
      fails++; $display("FAIL wall_hit x=%0d hit=%0d step=%0d exp x=15 hit=1 step=0", x, hit, step);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 4'($urandom_range(0, 15)));
      compares++;
      if ({x, y, dir, step, hit} !== {4'd15, 4'd0, 2'd0, 1'b0, 1'b1}) begin
        fails++; $display("FAIL dead_frozen c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, {4'd15, 4'd0, 2'd0, 1'b0, 1'b1});
      end
    end
    tick(1, 1, 4'b0001);
    compares++;
    if (x !== 4'd0 || y !== 4'd0 || hit !== 1'b0 || step !== 1'b0) begin
      fails++; $display("FAIL restart x=%0d y=%0d hit=%0d step=%0d exp all 0", x, y, hit, step);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL wall_after c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 4'b0000);
    tick(0, 1, 4'b0100);
    repeat (6) tick(0, 1, 4'b0000);
    #3 reset = 1'b0;
    #1;
    model_reset();
    compares++;
    if ({x, y, dir, step, hit} !== 12'h000) begin
      fails++; $display("FAIL async_reset got=%h exp=%h", {x, y, dir, step, hit}, 12'h000);
    end
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 4'b0000);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL post_reset c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit rs, en;
    bit [3:0] b;
    int r;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 80);
      r  = $urandom_range(0, 99);
      if (r < 12)      b = 4'(1 << $urandom_range(0, 3));
      else if (r < 15) b = 4'($urandom_range(0, 15));
      else             b = 4'b0000;
      tick(rs, en, b);
      compares++;
      if ({x, y, dir, step, hit} !== exp_vec()) begin
        fails++; $display("FAIL random c=%0d got=%h exp=%h", i, {x, y, dir, step, hit}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_reversal();
    test_multi_enable();
    test_wall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
